fpro_mmio_initiator: RTL and testbench
======================================

// Module: fpro_mmio_initiator
// PURPOSE
//  Bus-master end of the FPRO MMIO bus. Feeds the mmio_* inputs of the MMIO subsystem (slot controller).
//  Accepts read/write commands on a valid/ready port and queues them in a FIFO of depth FIFO_DEPTH.
//  Issues each command as a one-cycle FPRO transaction and returns read data on a response handshake.
//  Used by bridges and test harnesses that drive the slot peripherals without the CPU.
// PARAMETERS
//  FIFO_DEPTH  4   command queue entries; power of two, >=2
// PORTS
//  clk           in   1   system clock; all logic rising-edge
//  rst           in   1   asynchronous, active-high reset
//  cmd_valid     in   1   command offered
//  cmd_ready     out  1   queue can accept; equals !full
//  cmd_wr        in   1   1 = write, 0 = read
//  cmd_addr      in   21  word address: [10:5] slot, [4:0] register
//  cmd_wr_data   in   32  write data; ignored for reads
//  rsp_valid     out  1   read data available
//  rsp_ready     in   1   consumer takes rsp_data
//  rsp_data      out  32  captured mmio_rd_data
//  mmio_cs       out  1   FPRO chip select; registered
//  mmio_wr       out  1   FPRO write strobe; registered
//  mmio_rd       out  1   FPRO read strobe; registered
//  mmio_addr     out  21  FPRO address; registered
//  mmio_wr_data  out  32  FPRO write data; registered
//  mmio_rd_data  in   32  FPRO read data; valid combinationally while cs&rd
//  busy          out  1   FIFO non-empty, or FSM not IDLE
// BEHAVIOUR
//  Reset (async, immediate):
//   - FIFO empty; cmd_ready=1.
//   - FSM=IDLE.
//   - All mmio_* outputs = 0.
//   - rsp_valid=0, rsp_data=0, busy=0.
//   - Asserting rst mid-transaction drops mmio_cs at once and discards queued commands and any pending response.
//  FIFO:
//   - Push when cmd_valid&cmd_ready. Pop when the FSM loads the head.
//   - Pointers wrap modulo FIFO_DEPTH. A count register tracks occupancy.
//   - Push and pop in the same cycle leave the count unchanged.
//   - cmd_ready is derived from the registered count, so a full FIFO refuses a push even in a cycle where it pops.
//  FSM:
//   - IDLE:
//     - if FIFO non-empty: pop head, register it onto mmio_* with cs=1, wr=cmd_wr, rd=!cmd_wr; go ISSUE.
//     - else keep cs=wr=rd=0.
//   - ISSUE (cs high exactly this one cycle):
//     - read: rsp_data<=mmio_rd_data at the end of the cycle; rsp_valid<=1; go RESP.
//     - write, FIFO non-empty: load the next head directly. cs stays high and this is a new transaction; go ISSUE.
//     - write, FIFO empty: drop cs/wr/rd; go IDLE.
//   - RESP:
//     - mmio_cs=wr=rd=0. Hold rsp_valid and rsp_data stable until rsp_valid&rsp_ready.
//     - On that handshake: rsp_valid<=0, then the same next-state/load rules as IDLE. A queued command is issued the next cycle.
//  Timing:
//   - Latency from cmd accept to mmio_cs high is 2 cycles when idle.
//   - Read: rsp_valid rises 1 cycle after its ISSUE cycle.
//   - Writes stream at 1 per cycle. Each read blocks issue until its response is consumed.
//  Addresses and data pass through unmodified. No response is produced for writes.
//  mmio_addr and mmio_wr_data hold their last value while cs=0. wr and rd are never both 1.
// TESTING
//  1. Reset:
//     - assert rst mid-ISSUE: mmio_cs=0 in the same cycle; rsp_valid=0; cmd_ready=1; busy=0.
//  2. Single write:
//     - push wr addr=21'h00041 (slot2 reg1), data=32'hA5A5_0003.
//     - 2 cycles later: one cycle of cs=1, wr=1, rd=0 with that addr/data; no rsp_valid.
//  3. Single read:
//     - push rd addr=21'h00060; slave drives 32'h0000_000F.
//     - rsp_valid=1 with rsp_data=32'h0000_000F; rsp_data held 5 cycles under rsp_ready=0, cleared 1 cycle after rsp_ready=1.
//  4. Write burst:
//     - push 4 writes back-to-back.
//     - cmd_ready falls at full; cs high for 4 consecutive cycles with addresses in push order.
//     - a 5th push waits until cmd_ready returns.
//  5. Read blocking:
//     - queue rd, wr, rd; hold rsp_ready=0.
//     - the wr is not issued until the first rsp is taken; the second read returns data from its own address.
//  6. Full plus pop:
//     - FIFO full, FSM pops in the same cycle as cmd_valid=1.
//     - push refused (cmd_ready=0); count becomes FIFO_DEPTH-1; accepted next cycle.

Source files
------------

// File: rtl/fpro_mmio_initiator.sv
// FPRO MMIO bus master.
// Commands arrive on a valid/ready port and wait in a small FIFO. The FSM
// issues each one as a single-cycle chip-select transaction on the mmio_*
// bus. Read data is captured into a response register that is held until
// the consumer takes it. Writes stream back-to-back. Each read stalls
// further issue until its response has been consumed.
module fpro_mmio_initiator #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [20:0] cmd_addr,
  input  logic [31:0] cmd_wr_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        mmio_cs,
  output logic        mmio_wr,
  output logic        mmio_rd,
  output logic [20:0] mmio_addr,
  output logic [31:0] mmio_wr_data,
  input  logic [31:0] mmio_rd_data,
  output logic        busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  // Command storage; contents need no reset because occupancy is tracked by count_q.
  logic        mem_wr_q   [FIFO_DEPTH];
  logic [20:0] mem_addr_q [FIFO_DEPTH];
  logic [31:0] mem_data_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        push;
  logic        pop;
  logic        fifo_empty;
  logic        head_wr;
  logic [20:0] head_addr;
  logic [31:0] head_data;

  state_t      state_q, state_d;
  logic        cs_q, cs_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [20:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        issue_next;

  // Ready comes from the registered count only, so a full queue refuses a
  // push even in a cycle where the FSM pops.
  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = (count_q != FULL_CNT);
  assign push       = cmd_valid && cmd_ready;

  assign head_wr    = mem_wr_q[rptr_q];
  assign head_addr  = mem_addr_q[rptr_q];
  assign head_data  = mem_data_q[rptr_q];

  // Write an accepted command into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_wr_q[wptr_q]   <= cmd_wr;
      mem_addr_q[wptr_q] <= cmd_addr;
      mem_data_q[wptr_q] <= cmd_wr_data;
    end
  end

  // Next pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Issue FSM: decides the next state and the next value of every bus and
  // response register. Whenever the FSM is free to start a transaction it
  // sets issue_next, and the head of the queue is loaded onto the bus.
  always_comb begin
    state_d     = state_q;
    cs_d        = cs_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    issue_next  = 1'b0;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        cs_d       = 1'b0;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        issue_next = !fifo_empty;
      end
      S_ISSUE: begin
        cs_d = 1'b0;
        wr_d = 1'b0;
        rd_d = 1'b0;
        if (rd_q) begin
          // Slave data is valid combinationally while cs&rd, so capture it now.
          rsp_data_d  = mmio_rd_data;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          // A write needs no response; chain straight into the next command.
          state_d    = S_IDLE;
          issue_next = !fifo_empty;
        end
      end
      S_RESP: begin
        cs_d = 1'b0;
        wr_d = 1'b0;
        rd_d = 1'b0;
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
          issue_next  = !fifo_empty;
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
      end
    endcase

    if (issue_next) begin
      pop     = 1'b1;
      state_d = S_ISSUE;
      cs_d    = 1'b1;
      wr_d    = head_wr;
      rd_d    = !head_wr;
      addr_d  = head_addr;
      // Write data is only meaningful for writes; keep the last value across reads.
      wdata_d = head_wr ? head_data : wdata_q;
    end
  end

  // FSM state, registered bus outputs and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign mmio_cs      = cs_q;
  assign mmio_wr      = wr_q;
  assign mmio_rd      = rd_q;
  assign mmio_addr    = addr_q;
  assign mmio_wr_data = wdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign busy         = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_fpro_mmio_initiator.sv
// Directed bench for fpro_mmio_initiator with a bus/response scoreboard.
module tb_fpro_mmio_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [20:0] cmd_addr;
  logic [31:0] cmd_wr_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        mmio_cs;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [31:0] mmio_rd_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        wr;
    logic [20:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_txn[$];
  logic [31:0] exp_rsp[$];

  fpro_mmio_initiator #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wr       (cmd_wr),
    .cmd_addr     (cmd_addr),
    .cmd_wr_data  (cmd_wr_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .mmio_cs      (mmio_cs),
    .mmio_wr      (mmio_wr),
    .mmio_rd      (mmio_rd),
    .mmio_addr    (mmio_addr),
    .mmio_wr_data (mmio_wr_data),
    .mmio_rd_data (mmio_rd_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Slave model: one special register, everything else echoes its address.
  function automatic logic [31:0] slave_data(input logic [20:0] a);
    if (a == 21'h00060) return 32'h0000_000F;
    return {11'h5A5, a};
  endfunction

  assign mmio_rd_data = (mmio_cs && mmio_rd) ? slave_data(mmio_addr) : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wr, input logic [20:0] a, input logic [31:0] d);
    int   n;
    txn_t t;
    n           = 0;
    cmd_valid   = 1'b1;
    cmd_wr      = wr;
    cmd_addr    = a;
    cmd_wr_data = d;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_accept", cmd_ready, 1'b1);
    if (cmd_ready) begin
      t.wr   = wr;
      t.addr = a;
      t.data = d;
      exp_txn.push_back(t);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  // Bus and response monitor, sampled on the falling edge.
  always @(negedge clk) begin : mon
    txn_t        t;
    logic [31:0] r;
    if (!rst && mmio_cs) begin
      chk("wr_rd_exclusive", {31'd0, mmio_wr & mmio_rd}, 32'd0);
      chk("cs_expected", {31'd0, exp_txn.size() != 0}, 32'd1);
      if (exp_txn.size() != 0) begin
        t = exp_txn.pop_front();
        chk("sb_mmio_wr", mmio_wr, t.wr);
        chk("sb_mmio_rd", mmio_rd, !t.wr);
        chk("sb_mmio_addr", mmio_addr, t.addr);
        if (t.wr) chk("sb_mmio_wr_data", mmio_wr_data, t.data);
        else      exp_rsp.push_back(slave_data(t.addr));
      end
    end
    if (!rst && rsp_valid && rsp_ready) begin
      chk("rsp_expected", {31'd0, exp_rsp.size() != 0}, 32'd1);
      if (exp_rsp.size() != 0) begin
        r = exp_rsp.pop_front();
        chk("sb_rsp_data", rsp_data, r);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_wr      = 1'b0;
    cmd_addr    = '0;
    cmd_wr_data = '0;
    rsp_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", mmio_cs, 1'b0);
    chk("rst_wr", mmio_wr, 1'b0);
    chk("rst_rd", mmio_rd, 1'b0);
    chk("rst_addr", mmio_addr, 21'h0);
    chk("rst_wdata", mmio_wr_data, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Single write: cs two cycles after acceptance, for exactly one cycle.
    push(1'b1, 21'h00041, 32'hA5A5_0003);
    chk("wr_cs_lat1", mmio_cs, 1'b0);
    tick();
    chk("wr_cs", mmio_cs, 1'b1);
    chk("wr_wr", mmio_wr, 1'b1);
    chk("wr_rd", mmio_rd, 1'b0);
    chk("wr_addr", mmio_addr, 21'h00041);
    chk("wr_data", mmio_wr_data, 32'hA5A5_0003);
    tick();
    chk("wr_cs_drop", mmio_cs, 1'b0);
    chk("wr_no_rsp", rsp_valid, 1'b0);
    chk("wr_addr_hold", mmio_addr, 21'h00041);
    tick();

    // Single read with response held under backpressure.
    push(1'b0, 21'h00060, 32'h0);
    chk("rd_cs_lat1", mmio_cs, 1'b0);
    tick();
    chk("rd_cs", mmio_cs, 1'b1);
    chk("rd_rd", mmio_rd, 1'b1);
    chk("rd_wr", mmio_wr, 1'b0);
    tick();
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_rsp_data", rsp_data, 32'h0000_000F);
    chk("rd_cs_drop", mmio_cs, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rd_hold_valid", rsp_valid, 1'b1);
      chk("rd_hold_data", rsp_data, 32'h0000_000F);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rd_rsp_clear", rsp_valid, 1'b0);
    chk("rd_busy_clear", busy, 1'b0);
    tick();

    // Write burst filling the queue behind a blocked read, then full-plus-pop.
    push(1'b0, 21'h0007F, 32'h0);
    for (int i = 0; i < 4; i++) push(1'b1, 21'(21'h00100 + i), 32'hB000_0000 + i);
    chk("full_ready", cmd_ready, 1'b0);
    chk("full_rsp_valid", rsp_valid, 1'b1);
    chk("full_rsp_data", rsp_data, {11'h5A5, 21'h0007F});
    cmd_valid   = 1'b1;
    cmd_wr      = 1'b1;
    cmd_addr    = 21'h00104;
    cmd_wr_data = 32'hB000_0004;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("full_hold_ready", cmd_ready, 1'b0);
      chk("full_hold_cs", mmio_cs, 1'b0);
      chk("full_busy", busy, 1'b1);
    end
    rsp_ready = 1'b1;
    chk("full_pop_ready", cmd_ready, 1'b0);
    tick();
    rsp_ready = 1'b0;
    chk("after_pop_ready", cmd_ready, 1'b1);
    begin
      txn_t t5;
      t5.wr   = 1'b1;
      t5.addr = 21'h00104;
      t5.data = 32'hB000_0004;
      exp_txn.push_back(t5);
    end
    chk("burst_cs0", mmio_cs, 1'b1);
    chk("burst_addr0", mmio_addr, 21'h00100);
    chk("burst_rsp_clear", rsp_valid, 1'b0);
    tick();
    cmd_valid = 1'b0;
    chk("burst_cs1", mmio_cs, 1'b1);
    chk("burst_addr1", mmio_addr, 21'h00101);
    for (int i = 2; i < 5; i++) begin
      tick();
      chk("burst_cs", mmio_cs, 1'b1);
      chk("burst_addr", mmio_addr, 21'(21'h00100 + i));
    end
    tick();
    chk("burst_end_cs", mmio_cs, 1'b0);
    chk("burst_end_busy", busy, 1'b0);
    tick();

    // Read blocking: rd, wr, rd with the first response withheld.
    push(1'b0, 21'h00123, 32'h0);
    push(1'b1, 21'h00200, 32'hC0FF_EE01);
    push(1'b0, 21'h00345, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("blk_cs", mmio_cs, 1'b0);
      chk("blk_rsp_valid", rsp_valid, 1'b1);
      chk("blk_rsp_data", rsp_data, {11'h5A5, 21'h00123});
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("blk_wr_cs", mmio_cs, 1'b1);
    chk("blk_wr_wr", mmio_wr, 1'b1);
    chk("blk_wr_addr", mmio_addr, 21'h00200);
    chk("blk_rsp_clear", rsp_valid, 1'b0);
    tick();
    chk("blk_rd2_cs", mmio_cs, 1'b1);
    chk("blk_rd2_rd", mmio_rd, 1'b1);
    chk("blk_rd2_addr", mmio_addr, 21'h00345);
    tick();
    chk("blk_rd2_valid", rsp_valid, 1'b1);
    chk("blk_rd2_data", rsp_data, {11'h5A5, 21'h00345});
    chk("blk_rd2_cs_drop", mmio_cs, 1'b0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("blk_rsp_done", rsp_valid, 1'b0);
    chk("blk_busy_done", busy, 1'b0);
    chk("sb_txn_drained", exp_txn.size(), 32'd0);
    chk("sb_rsp_drained", exp_rsp.size(), 32'd0);
    tick();

    // Reset in the middle of an ISSUE cycle with a command still queued.
    push(1'b1, 21'h00400, 32'h0000_0001);
    push(1'b1, 21'h00401, 32'h0000_0002);
    push(1'b1, 21'h00402, 32'h0000_0003);
    chk("mid_pre_cs", mmio_cs, 1'b1);
    chk("mid_pre_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cs", mmio_cs, 1'b0);
    chk("mid_rst_wr", mmio_wr, 1'b0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_ready", cmd_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    exp_txn.delete();
    exp_rsp.delete();
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_cs", mmio_cs, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
